// File: rtl/pc_sequencer_pkg.sv
// Shared types and default widths for the program-counter / fetch-sequencing stage.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  localparam int PC_W_DEF  = 10;
  localparam int LUT_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pc_sequencer_if.sv
// Host/decoder/ALU-facing signal bundle of the sequencer; the host drives controls, the sequencer drives status.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_W = LUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             start;
  logic             stall;
  logic             halt_req;
  logic             jump_en;
  logic [LUT_W-1:0] jump_idx;
  logic             branch_en;
  logic [PC_W-1:0]  pc;
  logic             running;
  logic             done;
  logic [CNT_W-1:0] retired;

  modport master (
    output start, stall, halt_req, jump_en, jump_idx, branch_en,
    input  pc, running, done, retired
  );

  modport slave (
    input  start, stall, halt_req, jump_en, jump_idx, branch_en,
    output pc, running, done, retired
  );

endinterface

// File: rtl/pc_sequencer_jump_lut.sv
// Combinational jump-target ROM: maps a decoder jump index to an absolute fetch address.
module jump_lut
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_W = LUT_W_DEF
) (
  input  logic [LUT_W-1:0] addr,
  output logic [PC_W-1:0]  target
);

  // Entries are written at full precision and sized to PC_W, so oversize values truncate.
  always_comb begin
    target = '0;
    case (int'(addr))
      0:       target = PC_W'(7);
      1:       target = PC_W'(1022);
      2:       target = PC_W'(12);
      3:       target = PC_W'(200);
      4:       target = PC_W'(50);
      5:       target = PC_W'(30);
      6:       target = PC_W'(1023);
      7:       target = PC_W'(512);
      8:       target = PC_W'(100);
      9:       target = PC_W'(1500);
      default: target = '0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: start/run/halt control, skip/jump/stall handling, retired counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int          PC_W     = PC_W_DEF,
  parameter int          LUT_W    = LUT_W_DEF,
  parameter int unsigned START_PC = 0,
  parameter int          CNT_W    = CNT_W_DEF
) (
  input  logic          CLK,
  input  logic          RESET_N,
  pc_sequencer_if.slave bus
);

  localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [LUT_W-1:0] lut_addr;
  logic [PC_W-1:0]  lut_target;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [PC_W-1:0] pc_adv(input logic [PC_W-1:0] p, input logic skip);
    return p + (skip ? PC_W'(2) : PC_W'(1));
  endfunction

  // The index is masked unless a jump is decoded, so a floating index cannot reach pc.
  assign lut_addr = bus.jump_en ? bus.jump_idx : '0;

  jump_lut #(
    .PC_W  (PC_W),
    .LUT_W (LUT_W)
  ) u_jump_lut (
    .addr   (lut_addr),
    .target (lut_target)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      SEQ_IDLE: begin
        if (bus.start) begin
          state_d   = SEQ_RUN;
          pc_d      = START_ADDR;
          retired_d = '0;
        end
      end
      SEQ_RUN: begin
        if (bus.start) begin
          pc_d      = START_ADDR;
          retired_d = '0;
        end else if (bus.halt_req) begin
          // HALT retires even when the memory side is stalling.
          state_d   = SEQ_DONE;
          retired_d = sat_inc(retired_q);
        end else if (!bus.stall) begin
          if (bus.jump_en) begin
            pc_d = lut_target;
          end else begin
            pc_d = pc_adv(pc_q, bus.branch_en);
          end
          retired_d = sat_inc(retired_q);
        end
      end
      SEQ_DONE: begin
        if (bus.start) begin
          state_d   = SEQ_RUN;
          pc_d      = START_ADDR;
          retired_d = '0;
        end
      end
      default: begin
        state_d   = SEQ_IDLE;
        pc_d      = START_ADDR;
        retired_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= SEQ_IDLE;
      pc_q      <= START_ADDR;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.running = (state_q == SEQ_RUN);
  assign bus.done    = (state_q == SEQ_DONE);
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

  localparam int PC_W  = 10;
  localparam int LUT_W = 5;
  localparam int NPC   = 1 << PC_W;
  localparam int MAXC  = (1 << 16) - 1;
  localparam int MAXS  = 7;

  logic             clk;
  logic             rst_n;
  logic             start, stall, halt_req, jump_en, branch_en;
  logic [LUT_W-1:0] jump_idx;

  int checks;
  int failures;

  // Behavioural model: state as 0=idle 1=run 2=done, counters as plain integers.
  int m_state, m_pc, m_ret, m_ret_s;
  int lut_m [32];

  pc_sequencer_if #(.PC_W(PC_W), .LUT_W(LUT_W), .CNT_W(16)) bus ();
  pc_sequencer_if #(.PC_W(PC_W), .LUT_W(LUT_W), .CNT_W(3))  bus_s ();

  assign bus.start     = start;
  assign bus.stall     = stall;
  assign bus.halt_req  = halt_req;
  assign bus.jump_en   = jump_en;
  assign bus.jump_idx  = jump_idx;
  assign bus.branch_en = branch_en;

  assign bus_s.start     = start;
  assign bus_s.stall     = stall;
  assign bus_s.halt_req  = halt_req;
  assign bus_s.jump_en   = jump_en;
  assign bus_s.jump_idx  = jump_idx;
  assign bus_s.branch_en = branch_en;

  pc_sequencer #(.PC_W(PC_W), .LUT_W(LUT_W), .START_PC(0), .CNT_W(16)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  pc_sequencer #(.PC_W(PC_W), .LUT_W(LUT_W), .START_PC(0), .CNT_W(3)) dut_s (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_retire();
    if (m_ret < MAXC) m_ret++;
    if (m_ret_s < MAXS) m_ret_s++;
  endfunction

  function automatic void model_step();
    if (rst_n !== 1'b1) begin
      m_state = 0; m_pc = 0; m_ret = 0; m_ret_s = 0;
    end else if (start === 1'b1) begin
      m_state = 1; m_pc = 0; m_ret = 0; m_ret_s = 0;
    end else if (m_state == 1) begin
      if (halt_req === 1'b1) begin
        m_state = 2;
        model_retire();
      end else if (stall !== 1'b1) begin
        if (jump_en === 1'b1) m_pc = lut_m[int'(jump_idx)] % NPC;
        else if (branch_en === 1'b1) m_pc = (m_pc + 2) % NPC;
        else m_pc = (m_pc + 1) % NPC;
        model_retire();
      end
    end
  endfunction

  task automatic idle_inputs();
    start = 0; stall = 0; halt_req = 0; jump_en = 0; branch_en = 0; jump_idx = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) start = 1;
      tick();
      checks++;
      if (bus.pc !== 10'd0 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.retired !== 16'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d pc=%0d run=%b done=%b ret=%0d want 0/0/0/0", i, bus.pc, bus.running, bus.done, bus.retired);
      end
    end
    start = 0;
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.pc !== 10'd0 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.retired !== 16'd0) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d pc=%0d run=%b done=%b ret=%0d want 0/0/0/0", i, bus.pc, bus.running, bus.done, bus.retired);
      end
    end
  endtask

  task automatic test_seq_skip();
    logic       br_pat [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [9:0] pc_exp [4] = '{10'd1, 10'd2, 10'd4, 10'd5};
    start = 1;
    tick();
    start = 0;
    checks++;
    if (bus.pc !== 10'd0 || bus.running !== 1'b1 || bus.retired !== 16'd0) begin
      failures++;
      $display("FAIL start_run pc=%0d run=%b ret=%0d want 0/1/0", bus.pc, bus.running, bus.retired);
    end
    for (int i = 0; i < 4; i++) begin
      branch_en = br_pat[i];
      tick();
      checks++;
      if (bus.pc !== pc_exp[i]) begin
        failures++;
        $display("FAIL seq_pc step=%0d got=%0d want=%0d", i, bus.pc, pc_exp[i]);
      end
    end
    branch_en = 0;
    checks++;
    if (bus.retired !== 16'd4) begin
      failures++;
      $display("FAIL seq_retired got=%0d want=4", bus.retired);
    end
  endtask

  task automatic test_jump_stall();
    logic [15:0] ret_before;
    jump_en = 1; jump_idx = 5'd0;
    tick();
    checks++;
    if (bus.pc !== 10'd7) begin
      failures++;
      $display("FAIL jump_to7 got=%0d want=7", bus.pc);
    end
    jump_idx = 5'd3; branch_en = 1;
    tick();
    checks++;
    if (bus.pc !== 10'd200) begin
      failures++;
      $display("FAIL jump_over_branch got=%0d want=200", bus.pc);
    end
    ret_before = 16'(m_ret);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      jump_en = 1'($urandom); branch_en = 1'($urandom); jump_idx = 5'($urandom);
      tick();
      checks++;
      if (bus.pc !== 10'd200 || bus.retired !== ret_before) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d pc=%0d ret=%0d want 200/%0d", i, bus.pc, bus.retired, ret_before);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [4:0] idx_s [5] = '{5'd1, 5'd0, 5'd0, 5'd6, 5'd9};
    logic       jmp_s [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       br_s  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [9:0] exp_s [5] = '{10'd1022, 10'd0, 10'd1, 10'd1023, 10'd476};
    for (int i = 0; i < 5; i++) begin
      jump_en = jmp_s[i]; jump_idx = idx_s[i]; branch_en = br_s[i];
      tick();
      checks++;
      if (bus.pc !== exp_s[i]) begin
        failures++;
        $display("FAIL wrap_pc step=%0d got=%0d want=%0d", i, bus.pc, exp_s[i]);
      end
    end
    jump_en = 0; jump_idx = 'x; branch_en = 1;
    tick();
    checks++;
    if (bus.pc !== 10'd478) begin
      failures++;
      $display("FAIL xidx_pc got=%0d want=478", bus.pc);
    end
    idle_inputs();
  endtask

  task automatic test_halt_restart();
    logic [15:0] ret_exp;
    jump_en = 1; jump_idx = 5'd2;
    tick();
    jump_en = 0;
    ret_exp = 16'(m_ret + 1);
    halt_req = 1; stall = 1;
    tick();
    halt_req = 0; stall = 0;
    checks++;
    if (bus.done !== 1'b1 || bus.running !== 1'b0 || bus.pc !== 10'd12 || bus.retired !== ret_exp) begin
      failures++;
      $display("FAIL halt_done done=%b run=%b pc=%0d ret=%0d want 1/0/12/%0d", bus.done, bus.running, bus.pc, bus.retired, ret_exp);
    end
    for (int i = 0; i < 3; i++) begin
      jump_en = 1; jump_idx = 5'd3; branch_en = 1'($urandom);
      tick();
      checks++;
      if (bus.done !== 1'b1 || bus.pc !== 10'd12 || bus.retired !== ret_exp) begin
        failures++;
        $display("FAIL done_hold cyc=%0d done=%b pc=%0d ret=%0d want 1/12/%0d", i, bus.done, bus.pc, bus.retired, ret_exp);
      end
    end
    idle_inputs();
    start = 1;
    tick();
    start = 0;
    checks++;
    if (bus.pc !== 10'd0 || bus.retired !== 16'd0 || bus.running !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL restart_from_done pc=%0d ret=%0d run=%b done=%b want 0/0/1/0", bus.pc, bus.retired, bus.running, bus.done);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (bus.retired !== 16'd10 || bus_s.retired !== 3'd7) begin
      failures++;
      $display("FAIL retired_sat wide=%0d narrow=%0d want 10/7", bus.retired, bus_s.retired);
    end
    halt_req = 1;
    tick();
    halt_req = 0;
    checks++;
    if (bus_s.retired !== 3'd7 || bus_s.done !== 1'b1 || bus.retired !== 16'd11) begin
      failures++;
      $display("FAIL halt_sat narrow=%0d done=%b wide=%0d want 7/1/11", bus_s.retired, bus_s.done, bus.retired);
    end
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset_midrun();
    jump_en = 1; jump_idx = 5'd4;
    tick();
    checks++;
    if (bus.pc !== 10'd50) begin
      failures++;
      $display("FAIL jump_to50 got=%0d want=50", bus.pc);
    end
    rst_n = 0; jump_idx = 5'd3;
    tick();
    checks++;
    if (bus.pc !== 10'd0 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.retired !== 16'd0) begin
      failures++;
      $display("FAIL reset_midrun pc=%0d run=%b done=%b ret=%0d want 0/0/0/0", bus.pc, bus.running, bus.done, bus.retired);
    end
    idle_inputs();
    rst_n = 1;
    start = 1;
    tick();
    start = 0; jump_en = 1; jump_idx = 5'd5;
    tick();
    jump_en = 0;
    checks++;
    if (bus.pc !== 10'd30) begin
      failures++;
      $display("FAIL jump_to30 got=%0d want=30", bus.pc);
    end
    start = 1; branch_en = 1; halt_req = 1;
    tick();
    idle_inputs();
    checks++;
    if (bus.pc !== 10'd0 || bus.retired !== 16'd0 || bus.running !== 1'b1) begin
      failures++;
      $display("FAIL restart_in_run pc=%0d ret=%0d run=%b want 0/0/1", bus.pc, bus.retired, bus.running);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 79) != 0);
      start     = ($urandom_range(0, 24) == 0);
      halt_req  = ($urandom_range(0, 15) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      jump_en   = ($urandom_range(0, 3) == 0);
      branch_en = 1'($urandom);
      jump_idx  = (!jump_en && $urandom_range(0, 3) == 0) ? 'x : 5'($urandom_range(0, 11));
      tick();
      checks++;
      if (bus.pc !== 10'(m_pc) || bus.running !== (m_state == 1) || bus.done !== (m_state == 2)
          || bus.retired !== 16'(m_ret) || bus_s.retired !== 3'(m_ret_s)) begin
        failures++;
        $display("FAIL rand cyc=%0d pc=%0d run=%b done=%b ret=%0d sret=%0d want pc=%0d st=%0d ret=%0d sret=%0d",
                 i, bus.pc, bus.running, bus.done, bus.retired, bus_s.retired, m_pc, m_state, m_ret, m_ret_s);
      end
    end
    idle_inputs();
    rst_n = 1;
  endtask

  initial begin
    checks = 0; failures = 0;
    m_state = 0; m_pc = 0; m_ret = 0; m_ret_s = 0;
    for (int i = 0; i < 32; i++) lut_m[i] = 0;
    lut_m[0] = 7;   lut_m[1] = 1022; lut_m[2] = 12;  lut_m[3] = 200; lut_m[4] = 50;
    lut_m[5] = 30;  lut_m[6] = 1023; lut_m[7] = 512; lut_m[8] = 100; lut_m[9] = 1500;
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_seq_skip();
    test_jump_stall();
    test_wrap();
    test_halt_restart();
    test_saturate();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
